// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@60 Hz timing constants shared by the raster timing block.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int COUNT_W  = 11;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; wrap counter with blank/sync flags registered
// from the next count so flags never lag the count they describe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = H_ACTIVE,
    parameter int SYNC_START = H_ACTIVE + H_FP,
    parameter int SYNC_END   = H_ACTIVE + H_FP + H_SYNC
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               blank,
    output logic               sync,
    output logic               wrap
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);
    // One extra bit so bounds equal to 2048 still compare correctly.
    localparam logic [COUNT_W:0] ACT_B = (COUNT_W + 1)'(ACTIVE);
    localparam logic [COUNT_W:0] SS_B  = (COUNT_W + 1)'(SYNC_START);
    localparam logic [COUNT_W:0] SE_B  = (COUNT_W + 1)'(SYNC_END);

    logic [COUNT_W-1:0] nxt;
    logic [COUNT_W:0]   nxt_x;

    always_comb begin
        wrap  = en && count == LAST;
        nxt   = wrap ? '0 : en ? count + 1'b1 : count;
        nxt_x = {1'b0, nxt};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            count <= '0;
            blank <= 1'b0;
            sync  <= 1'b0;
        end else begin
            count <= nxt;
            blank <= nxt_x >= ACT_B;
            sync  <= nxt_x >= SS_B && nxt_x < SE_B;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster counters, sync/blank flags and frame strobe.
// frame_start is generated only when VGA_TIMING_FRAME_STROBE_EN is defined; otherwise tied low.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic               pclk,
    input  logic               rst,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic [15:0]        xdim,
    output logic [15:0]        ydim
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HT > 2048 || VT > 2048) begin : g_bad_total
        $error("vga_timing: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    logic h_wrap;
    logic v_wrap;

    assign xdim = 16'(HT);
    assign ydim = 16'(VT);

    vga_axis_counter #(
        .TOTAL      (HT),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h (
        .pclk  (pclk),
        .rst   (rst),
        .en    (1'b1),
        .count (hcount),
        .blank (hblnk),
        .sync  (hsync),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (VT),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v (
        .pclk  (pclk),
        .rst   (rst),
        .en    (h_wrap),
        .count (vcount),
        .blank (vblnk),
        .sync  (vsync),
        .wrap  (v_wrap)
    );

`ifdef VGA_TIMING_FRAME_STROBE_EN
    // v_wrap is the last pixel of the frame, so the strobe lands on the wrapped (0,0).
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) frame_start <= 1'b0;
        else     frame_start <= v_wrap;
    end
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
    assign frame_start   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of a small-geometry instance (8x7 frame) and the default 1056x628 instance.
module tb_vga_timing;

`ifdef VGA_TIMING_FRAME_STROBE_EN
    localparam logic FS = 1'b1;
`else
    localparam logic FS = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hb, vb, hs, vs, fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t e;
    } vec_t;

    logic pclk = 1'b0;
    logic rst_s, rst_b;
    logic [10:0] hc_s, vc_s, hc_b, vc_b;
    logic hb_s, vb_s, hs_s, vs_s, fs_s;
    logic hb_b, vb_b, hs_b, vs_b, fs_b;
    logic [15:0] xd_s, yd_s, xd_b, yd_b;
    obs_t obs_s;
    int checks = 0;
    int failures = 0;
    int n = 0;

    always #5 pclk = ~pclk;

    // Small geometry: H 4+1+2+1=8 (hblnk h>=4, hsync h=5..6), V 3+1+2+1=7 (vblnk v>=3, vsync v=4..5).
    vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .pclk(pclk), .rst(rst_s), .hcount(hc_s), .vcount(vc_s),
        .hblnk(hb_s), .vblnk(vb_s), .hsync(hs_s), .vsync(vs_s),
        .frame_start(fs_s), .xdim(xd_s), .ydim(yd_s)
    );

    vga_timing dut_b (
        .pclk(pclk), .rst(rst_b), .hcount(hc_b), .vcount(vc_b),
        .hblnk(hb_b), .vblnk(vb_b), .hsync(hs_b), .vsync(vs_b),
        .frame_start(fs_b), .xdim(xd_b), .ydim(yd_b)
    );

    assign obs_s = {hc_s, vc_s, hb_s, vb_s, hs_s, vs_s, fs_s};

    function automatic vec_t mk(int cyc, int h, int v, logic hb, logic vb, logic hs, logic vs, logic fs);
        vec_t r;
        r.n = cyc;
        r.e = {11'(h), 11'(v), hb, vb, hs, vs, fs};
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_obs(string name, obs_t exp);
        checks++;
        if (obs_s !== exp) begin
            failures++;
            $display("FAIL %s: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b expected h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b",
                     name, obs_s.h, obs_s.v, obs_s.hb, obs_s.vb, obs_s.hs, obs_s.vs, obs_s.fs,
                     exp.h, exp.v, exp.hb, exp.vb, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
        n++;
    endtask

    initial begin
        vec_t vecs[15];
        int fs_cnt, h_err, v_err, f_err, dim_err, first_hb, first_hs, last_hs, hs_cnt;
        vecs[0]  = mk(0,   0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(3,   3, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(4,   4, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(5,   5, 0, 1, 0, 1, 0, 0);
        vecs[4]  = mk(6,   6, 0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(7,   7, 0, 1, 0, 0, 0, 0);
        vecs[6]  = mk(8,   0, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(24,  0, 3, 0, 1, 0, 0, 0);
        vecs[8]  = mk(29,  5, 3, 1, 1, 1, 0, 0);
        vecs[9]  = mk(32,  0, 4, 0, 1, 0, 1, 0);
        vecs[10] = mk(47,  7, 5, 1, 1, 0, 1, 0);
        vecs[11] = mk(48,  0, 6, 0, 1, 0, 0, 0);
        vecs[12] = mk(55,  7, 6, 1, 1, 0, 0, 0);
        vecs[13] = mk(56,  0, 0, 0, 0, 0, 0, FS);
        vecs[14] = mk(57,  1, 0, 0, 0, 0, 0, 0);

        rst_s = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge pclk);
        chk_obs("small_reset", '0);
        chk("big_reset_h", hc_b, 0);
        chk("big_reset_v", vc_b, 0);
        chk("big_reset_flags", {hb_b, vb_b, hs_b, vs_b, fs_b}, 0);
        chk("xdim_reset", xd_b, 1056);
        chk("ydim_reset", yd_b, 628);
        chk("small_dims", {xd_s, yd_s}, {16'd8, 16'd7});

        rst_s = 1'b0;
        n = 0;
        foreach (vecs[i]) begin
            while (n < vecs[i].n) step();
            chk_obs($sformatf("vec_n%0d", vecs[i].n), vecs[i].e);
        end
        while (n < 112) step();
        chk_obs("second_frame_start", {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, FS});

        // Mid-frame reset at (4,2): outputs clear before any further clock edge.
        while (n < 132) step();
        chk_obs("pre_reset_pos", {11'd4, 11'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        #2 rst_s = 1'b1;
        #1 chk_obs("async_reset", '0);
        repeat (3) @(negedge pclk);
        chk_obs("held_reset", '0);
        rst_s = 1'b0;
        n = 0;
        fs_cnt = 0;
        for (int k = 1; k < 56; k++) begin
            step();
            fs_cnt += int'(fs_s);
            if (k == 1) chk_obs("restart_h1", {11'd1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        chk("no_early_frame_start", fs_cnt, 0);
        step();
        chk_obs("frame_after_reset", {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, FS});

        // Default geometry: one full line plus the wrap edge.
        rst_b = 1'b0;
        n = 0;
        h_err = 0; v_err = 0; f_err = 0; dim_err = 0;
        first_hb = -1; first_hs = -1; last_hs = -1; hs_cnt = 0; fs_cnt = 0;
        for (int k = 1; k <= 1056; k++) begin
            step();
            if (hc_b != 11'(k % 1056)) h_err++;
            if (vc_b != 11'(k / 1056)) v_err++;
            if (hb_b != (k % 1056 >= 800) || vb_b || vs_b) f_err++;
            if (hb_b && first_hb < 0) first_hb = int'(hc_b);
            if (hs_b) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(hc_b);
                last_hs = int'(hc_b);
            end
            fs_cnt += int'(fs_b);
            if (xd_b != 16'd1056 || yd_b != 16'd628) dim_err++;
        end
        chk("big_hcount_seq_errs", h_err, 0);
        chk("big_vcount_seq_errs", v_err, 0);
        chk("big_blank_errs", f_err, 0);
        chk("first_hblnk_at", first_hb, 800);
        chk("first_hsync_at", first_hs, 840);
        chk("last_hsync_at", last_hs, 967);
        chk("hsync_width", hs_cnt, 128);
        chk("wrap_h_v", {hc_b, vc_b}, {11'd0, 11'd1});
        chk("wrap_flags_low", {hb_b, hs_b}, 0);
        chk("big_no_frame_start", fs_cnt, 0);
        chk("dims_constant_errs", dim_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
